// File: rtl/packet_relay_if.sv
// packet_relay_if: read port of the show-ahead local FIFO.
// localDout/localEmpty come from the FIFO; localRE is a one-cycle pop.
interface packet_relay_if #(
  parameter int PAYLOAD_W = 54
);
  logic [PAYLOAD_W-1:0] localDout;
  logic                 localEmpty;
  logic                 localRE;

  modport master (
    input  localDout,
    input  localEmpty,
    output localRE
  );

  modport slave (
    output localDout,
    output localEmpty,
    input  localRE
  );
endinterface

// File: rtl/packet_relay.sv
// packet_relay: daisy-chain serial relay with a local frame source.
// Ports: clk/rst, DIR/ID/PRIO/TXEN control, lif local FIFO port,
// DATxi/DATxo serial data, XOFFxi/XOFFxo back-pressure, pad enables,
// parErrCnt/ovfCnt drop counters, txBusy.
module packet_relay #(
  parameter int PAYLOAD_W = 54,
  parameter int ID_W      = 4,
  parameter int LOG_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            DIR,
  input  logic [ID_W-1:0] ID,
  input  logic [3:0]      PRIO,
  input  logic            TXEN,
  packet_relay_if.master  lif,
  input  logic            DATLi,
  input  logic            DATRi,
  output logic            DATLo,
  output logic            DATRo,
  input  logic            XOFFLi,
  input  logic            XOFFRi,
  output logic            XOFFLo,
  output logic            XOFFRo,
  output logic            DATLoen,
  output logic            DATRoen,
  output logic            XOFFLoen,
  output logic            XOFFRoen,
  output logic [7:0]      parErrCnt,
  output logic [7:0]      ovfCnt,
  output logic            txBusy
);

  localparam int DW      = ID_W + PAYLOAD_W;
  localparam int FRAME_W = DW + 2;
  localparam int DEPTH   = 1 << LOG_DEPTH;
  localparam int CW      = $clog2(FRAME_W + 1);

  localparam logic [LOG_DEPTH:0] C_FULL = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] C_HIGH = (LOG_DEPTH+1)'(DEPTH - 1);
  localparam logic [CW-1:0] C_RX_LAST = CW'(FRAME_W - 2);
  localparam logic [CW-1:0] C_TX_LAST = CW'(FRAME_W - 1);

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP
  } tx_state_t;

  // pads
  assign DATLoen  = DIR;
  assign DATRoen  = ~DIR;
  assign XOFFRoen = DIR;
  assign XOFFLoen = ~DIR;

  logic w_rx_in;
  logic w_xoff_in;

  assign w_rx_in   = DIR ? DATLi : DATRi;
  assign w_xoff_in = DIR ? XOFFRi : XOFFLi;

  // receiver
  rx_state_t     r_rx_state;
  rx_state_t     w_rx_next;
  logic [CW-1:0] r_rx_cnt;
  logic [DW:0]   r_rx_sr;
  logic          r_rx_done;
  logic          w_par_ok;
  logic          w_rx_wr;

  always_comb begin
    w_rx_next = r_rx_state;
    unique case (1'b1)
      (r_rx_state == RX_IDLE): begin
        if (w_rx_in) w_rx_next = RX_SHIFT;
      end
      (r_rx_state == RX_SHIFT): begin
        if (r_rx_cnt == C_RX_LAST) w_rx_next = RX_IDLE;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_sr    <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_done  <= 1'b0;
      if (r_rx_state == RX_SHIFT) begin
        r_rx_sr  <= {r_rx_sr[DW-1:0], w_rx_in};
        r_rx_cnt <= r_rx_cnt + CW'(1);
        if (r_rx_cnt == C_RX_LAST) r_rx_done <= 1'b1;
      end else begin
        r_rx_cnt <= '0;
      end
    end
  end

  // even parity: ID+payload plus parity bit must hold an even count of ones
  assign w_par_ok = ~^r_rx_sr;

  // through FIFO
  logic [DW-1:0]        r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_wp;
  logic [LOG_DEPTH-1:0] r_rp;
  logic [LOG_DEPTH:0]   r_cnt;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_thr_rd;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == C_FULL);
  assign w_rx_wr = r_rx_done & w_par_ok & ~w_full;

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_mem[r_wp] <= r_rx_sr[DW:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_rx_wr)  r_wp <= r_wp + LOG_DEPTH'(1);
      if (w_thr_rd) r_rp <= r_rp + LOG_DEPTH'(1);
      if (w_rx_wr & ~w_thr_rd)
        r_cnt <= r_cnt + (LOG_DEPTH+1)'(1);
      else if (~w_rx_wr & w_thr_rd)
        r_cnt <= r_cnt - (LOG_DEPTH+1)'(1);
    end
  end

  // drop counters; a parity failure is never also counted as overflow
  logic [7:0] r_perr;
  logic [7:0] r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr <= '0;
      r_ovf  <= '0;
    end else if (r_rx_done) begin
      if (!w_par_ok) begin
        if (r_perr != 8'hFF) r_perr <= r_perr + 8'd1;
      end else if (w_full) begin
        if (r_ovf != 8'hFF) r_ovf <= r_ovf + 8'd1;
      end
    end
  end

  assign parErrCnt = r_perr;
  assign ovfCnt    = r_ovf;

  // one slot left only counts as full while no frame is arriving
  logic w_xoff;

  assign w_xoff = w_full |
    ((r_cnt == C_HIGH) & (r_rx_state == RX_IDLE));
  assign XOFFLo = ~rst & w_xoff;
  assign XOFFRo = ~rst & w_xoff;

  // transmitter
  tx_state_t           r_tx_state;
  tx_state_t           w_tx_next;
  logic [CW-1:0]       r_tx_cnt;
  logic [FRAME_W-1:0]  r_tx_sr;
  logic [3:0]          r_tcnt;
  logic                w_sel_loc;
  logic                w_sel_thr;
  logic                w_can;
  logic                w_start;
  logic                w_loc_re;
  logic [DW-1:0]       w_tx_data;
  logic                w_tx_bit;

  assign w_sel_loc = ~lif.localEmpty &
    (w_empty | (r_tcnt == PRIO));
  assign w_sel_thr = ~w_sel_loc & ~w_empty;

  // an empty FIFO with a frame arriving defers the start
  assign w_can = ~rst & TXEN & ~w_xoff_in &
    ~(w_empty & (r_rx_state == RX_SHIFT));

  assign w_tx_data = w_sel_loc ? {ID, lif.localDout}
                               : r_mem[r_rp];

  always_comb begin
    w_tx_next = r_tx_state;
    w_start   = 1'b0;
    w_loc_re  = 1'b0;
    w_thr_rd  = 1'b0;
    unique case (1'b1)
      (r_tx_state == TX_IDLE): begin
        if (w_can & (w_sel_loc | w_sel_thr)) begin
          w_tx_next = TX_SEND;
          w_start   = 1'b1;
          w_loc_re  = w_sel_loc;
          w_thr_rd  = w_sel_thr;
        end
      end
      (r_tx_state == TX_SEND): begin
        if (r_tx_cnt == C_TX_LAST) w_tx_next = TX_GAP;
      end
      (r_tx_state == TX_GAP): begin
        w_tx_next = TX_IDLE;
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_sr    <= '0;
      r_tcnt     <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_start) begin
        r_tx_sr  <= {1'b1, w_tx_data, ^w_tx_data};
        r_tx_cnt <= '0;
        if (w_loc_re)
          r_tcnt <= '0;
        else if (r_tcnt < PRIO)
          r_tcnt <= r_tcnt + 4'd1;
      end else if (r_tx_state == TX_SEND) begin
        r_tx_sr  <= {r_tx_sr[FRAME_W-2:0], 1'b0};
        r_tx_cnt <= r_tx_cnt + CW'(1);
      end
    end
  end

  assign lif.localRE = w_loc_re;

  assign w_tx_bit = ~rst & (r_tx_state == TX_SEND) &
    r_tx_sr[FRAME_W-1];
  assign DATLo  = w_tx_bit;
  assign DATRo  = w_tx_bit;
  assign txBusy = ~rst & (r_tx_state == TX_SEND);

endmodule

// File: tb/tb_packet_relay.sv
// tb_packet_relay: random stimulus, queue reference model and
// scoreboard monitor for packet_relay.
module tb_packet_relay;

  localparam int PW = 54;
  localparam int IW = 4;
  localparam int DW = PW + IW;
  localparam int FW = DW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic DIR = 1'b0;
  logic [IW-1:0] ID = 4'h3;
  logic [3:0] PRIO = 4'd0;
  logic TXEN = 1'b1;
  logic DATLi = 1'b0;
  logic DATRi = 1'b0;
  logic XOFFLi = 1'b0;
  logic XOFFRi = 1'b0;
  logic DATLo, DATRo, XOFFLo, XOFFRo;
  logic DATLoen, DATRoen, XOFFLoen, XOFFRoen;
  logic [7:0] parErrCnt, ovfCnt;
  logic txBusy;

  packet_relay_if #(.PAYLOAD_W(PW)) lif();

  packet_relay #(
    .PAYLOAD_W(PW),
    .ID_W(IW),
    .LOG_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .DIR(DIR), .ID(ID),
    .PRIO(PRIO), .TXEN(TXEN), .lif(lif),
    .DATLi(DATLi), .DATRi(DATRi),
    .DATLo(DATLo), .DATRo(DATRo),
    .XOFFLi(XOFFLi), .XOFFRi(XOFFRi),
    .XOFFLo(XOFFLo), .XOFFRo(XOFFRo),
    .DATLoen(DATLoen), .DATRoen(DATRoen),
    .XOFFLoen(XOFFLoen), .XOFFRoen(XOFFRoen),
    .parErrCnt(parErrCnt), .ovfCnt(ovfCnt),
    .txBusy(txBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q[$];
  logic [PW-1:0] lq[$];
  logic [PW-1:0] lqm[$];
  logic [DW-1:0] tq[$];
  int perr_m = 0;
  int ovf_m = 0;
  int m_tcnt = 0;
  int re_pulses = 0;
  logic mdl_re;

  function automatic logic [FW-1:0] mk_frame(input logic [DW-1:0] d);
    return {1'b1, d, ^d};
  endfunction

  function automatic logic [DW-1:0] rnd_d();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  function automatic logic [PW-1:0] rnd_p();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // local FIFO model: show-ahead head word, popped on localRE
  initial begin
    lif.localDout  = '0;
    lif.localEmpty = 1'b1;
    forever begin
      @(negedge clk);
      mdl_re = lif.localRE;
      @(posedge clk);
      #1;
      if (mdl_re && !rst) begin
        if (lq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL localRE: got pop required none (empty)");
        end else begin
          void'(lq.pop_front());
          re_pulses++;
        end
      end
      lif.localEmpty = (lq.size() == 0);
      lif.localDout  = (lq.size() != 0) ? lq[0] : '0;
    end
  end

  // monitor: deserialise DATLo and compare against the scoreboard
  initial begin
    logic [FW-1:0] frm;
    logic [FW-1:0] e;
    int busy_err;
    int diff_err;
    bit abort;
    forever begin
      @(negedge clk);
      if (rst || DATLo !== 1'b1) continue;
      frm = '0;
      frm[FW-1] = 1'b1;
      busy_err = (txBusy === 1'b1) ? 0 : 1;
      diff_err = (DATRo === DATLo) ? 0 : 1;
      abort = 1'b0;
      for (int i = FW - 2; i >= 0; i--) begin
        @(negedge clk);
        if (rst) begin
          abort = 1'b1;
          break;
        end
        frm[i] = DATLo;
        if (txBusy !== 1'b1) busy_err++;
        if (DATRo !== DATLo) diff_err++;
      end
      if (abort) continue;
      chk("txBusy during frame", 64'(busy_err), 64'(0));
      chk("DATRo equals DATLo", 64'(diff_err), 64'(0));
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame: got %h required none", frm);
      end else begin
        e = exp_q.pop_front();
        if (frm !== e) begin
          errors++;
          $display("FAIL frame: got %h required %h", frm, e);
        end
      end
    end
  end

  task automatic push_local(input logic [PW-1:0] p);
    lq.push_back(p);
    lqm.push_back(p);
  endtask

  task automatic rx_model(input logic [DW-1:0] d, input bit bad);
    if (bad) perr_m++;
    else if (tq.size() == 16) ovf_m++;
    else tq.push_back(d);
  endtask

  // expected output order from the arbitration rule, everything queued
  task automatic predict();
    while (lqm.size() != 0 || tq.size() != 0) begin
      if (lqm.size() != 0 &&
          (tq.size() == 0 || m_tcnt == int'(PRIO))) begin
        exp_q.push_back(mk_frame({ID, lqm.pop_front()}));
        m_tcnt = 0;
      end else begin
        exp_q.push_back(mk_frame(tq.pop_front()));
        if (m_tcnt < int'(PRIO)) m_tcnt++;
      end
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit bad,
                            input bit left);
    logic [FW-1:0] f;
    f = mk_frame(d);
    if (bad) f[$urandom_range(1, DW)] ^= 1'b1;
    for (int i = FW - 1; i >= 0; i--) begin
      tick();
      if (left) DATLi = f[i];
      else DATRi = f[i];
    end
  endtask

  task automatic idle_line();
    tick();
    DATLi = 1'b0;
    DATRi = 1'b0;
  endtask

  task automatic rx_frame(input bit bad, input bit left);
    logic [DW-1:0] d;
    d = rnd_d();
    send_frame(d, bad, left);
    idle_line();
    rx_model(d, bad);
  endtask

  task automatic drain(input int maxc, input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || txBusy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(nm, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic wait_busy(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (txBusy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int b0;
    int lat;
    int cnt;
    int nt;
    int nl;
    int bad_i;
    bit ok;
    logic [DW-1:0] d;

    // reset: local word waiting, TXEN high, nothing may move
    lq.push_back(54'h2A5);
    lqm.push_back(54'h2A5);
    repeat (3) tick();
    @(negedge clk);
    chk("reset DATLo", 64'(DATLo), 64'(0));
    chk("reset DATRo", 64'(DATRo), 64'(0));
    chk("reset txBusy", 64'(txBusy), 64'(0));
    chk("reset localRE", 64'(lif.localRE), 64'(0));
    chk("reset XOFFLo", 64'(XOFFLo), 64'(0));
    chk("reset XOFFRo", 64'(XOFFRo), 64'(0));
    chk("reset parErrCnt", 64'(parErrCnt), 64'(0));
    chk("reset ovfCnt", 64'(ovfCnt), 64'(0));
    chk("DIR0 pad enables",
        64'({DATLoen, DATRoen, XOFFLoen, XOFFRoen}), 64'(4'b0110));
    tick();
    DIR = 1'b1;
    @(negedge clk);
    chk("DIR1 pad enables",
        64'({DATLoen, DATRoen, XOFFLoen, XOFFRoen}), 64'(4'b1001));
    tick();
    DIR = 1'b0;
    rst = 1'b0;

    // local-only traffic
    b0 = re_pulses;
    for (int i = 0; i < 4; i++) push_local(rnd_p());
    predict();
    drain(5 * 64 + 50, "local frames drained");
    chk("localRE pulses", 64'(re_pulses - b0), 64'(5));

    // receive with transmitter held: parity, XOFF, overflow
    tick();
    TXEN = 1'b0;
    ID = 4'($urandom_range(0, 15));
    bad_i = $urandom_range(0, 2);
    for (int i = 0; i < 3; i++) rx_frame(i == bad_i, 1'b0);
    settle();
    chk("parErrCnt one bad", 64'(parErrCnt), 64'(perr_m));
    while (tq.size() < 14) rx_frame(1'b0, 1'b0);
    settle();
    chk("XOFFLo at 14", 64'(XOFFLo), 64'(0));
    rx_frame(1'b0, 1'b0);
    settle();
    chk("XOFFLo at 15", 64'(XOFFLo), 64'(1));
    chk("XOFFRo at 15", 64'(XOFFRo), 64'(1));
    rx_frame(1'b0, 1'b0);
    settle();
    chk("XOFFLo full", 64'(XOFFLo), 64'(1));
    chk("ovfCnt before overflow", 64'(ovfCnt), 64'(ovf_m));
    rx_frame(1'b0, 1'b0);
    settle();
    chk("ovfCnt overflow", 64'(ovfCnt), 64'(ovf_m));
    rx_frame(1'b1, 1'b0);
    settle();
    chk("parErrCnt when full", 64'(parErrCnt), 64'(perr_m));
    chk("ovfCnt bad when full", 64'(ovfCnt), 64'(ovf_m));
    predict();
    tick();
    TXEN = 1'b1;
    drain(16 * 64 + 50, "through frames drained");
    settle();
    chk("XOFFLo after drain", 64'(XOFFLo), 64'(0));

    // parity bit to start bit latency of a through frame
    d = rnd_d();
    rx_model(d, 1'b0);
    predict();
    send_frame(d, 1'b0, 1'b0);
    lat = 99;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (DATLo === 1'b1 && lat == 99) lat = i;
      tick();
      DATRi = 1'b0;
    end
    chk("through latency", 64'(lat), 64'(3));
    drain(120, "latency frame drained");

    // PRIO=2: through, through, local
    tick();
    TXEN = 1'b0;
    PRIO = 4'd2;
    for (int i = 0; i < 8; i++) rx_frame(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push_local(rnd_p());
    settle();
    predict();
    tick();
    TXEN = 1'b1;
    drain(12 * 64 + 50, "PRIO2 order drained");

    // random mixes
    for (int r = 0; r < 3; r++) begin
      tick();
      TXEN = 1'b0;
      PRIO = 4'($urandom_range(0, 3));
      ID = 4'($urandom_range(0, 15));
      nt = $urandom_range(0, 8);
      nl = $urandom_range(1, 5);
      for (int i = 0; i < nt; i++)
        rx_frame($urandom_range(0, 3) == 0, 1'b0);
      for (int i = 0; i < nl; i++) push_local(rnd_p());
      settle();
      chk("parErrCnt random", 64'(parErrCnt), 64'(perr_m));
      predict();
      tick();
      TXEN = 1'b1;
      drain((nt + nl) * 64 + 50, "random mix drained");
    end

    // DIR=1: receive on DATLi, XOFFLi ignored
    tick();
    TXEN = 1'b0;
    DIR = 1'b1;
    XOFFLi = 1'b1;
    push_local(rnd_p());
    rx_frame(1'b0, 1'b1);
    settle();
    predict();
    tick();
    TXEN = 1'b1;
    drain(3 * 64 + 50, "DIR1 frames drained");
    tick();
    XOFFLi = 1'b0;
    DIR = 1'b0;

    // XOFF mid-frame finishes the frame and blocks the next
    tick();
    PRIO = 4'd0;
    push_local(rnd_p());
    push_local(rnd_p());
    predict();
    wait_busy(20, ok);
    chk("XOFF test start", 64'(ok), 64'(1));
    repeat (10) tick();
    XOFFLi = 1'b1;
    for (int i = 0; i < 80 && txBusy; i++) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (txBusy || lif.localRE) cnt++;
    end
    chk("XOFF blocks start", 64'(cnt), 64'(0));
    chk("frames left under XOFF", 64'(exp_q.size()), 64'(1));
    tick();
    XOFFLi = 1'b0;
    drain(150, "frame after XOFF");

    // reset at bit 30 of a frame
    tick();
    lq.push_back(rnd_p());
    wait_busy(20, ok);
    chk("reset test start", 64'(ok), 64'(1));
    repeat (30) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("DATLo in reset", 64'(DATLo), 64'(0));
    chk("txBusy in reset", 64'(txBusy), 64'(0));
    tick();
    @(negedge clk);
    chk("parErrCnt after reset", 64'(parErrCnt), 64'(0));
    chk("ovfCnt after reset", 64'(ovfCnt), 64'(0));
    tick();
    rst = 1'b0;
    tq.delete();
    perr_m = 0;
    ovf_m = 0;
    m_tcnt = 0;
    repeat (100) @(negedge clk);
    chk("no frame after reset", 64'(exp_q.size()), 64'(0));
    push_local(rnd_p());
    predict();
    drain(150, "frame after reset");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
